// File: rtl/final_mss_lite.sv
// Microcontroller-subsystem stand-in: UART_0 byte commands become APB3 transfers with
// UART replies, plus a UART_1 echo channel, GPO 31, a sampled ADC comparator and the fabric clock/reset.

module final_mss_lite_uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       valid,
  output logic       frame_err,
  output logic [7:0] data
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  rx_state_t       state, state_d;
  logic            rx_meta, rx_sync;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic            cnt_clr, sample, valid_d, err_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state;
    cnt_clr = 1'b0;
    sample  = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state)
      RX_IDLE:  if (!rx_sync) begin state_d = RX_START; cnt_clr = 1'b1; end
      RX_START: if (cnt == HALF_LAST) begin
                  cnt_clr = 1'b1;
                  state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
      RX_DATA:  if (cnt == BIT_LAST) begin
                  cnt_clr = 1'b1;
                  sample  = 1'b1;
                  if (bit_idx == 3'd7) state_d = RX_STOP;
                end
      RX_STOP:  if (cnt == BIT_LAST) begin
                  cnt_clr = 1'b1;
                  if (rx_sync) begin valid_d = 1'b1; state_d = RX_IDLE; end
                  else begin err_d = 1'b1; state_d = RX_WAIT; end
                end
      // A low stop bit must not be mistaken for the next start bit.
      RX_WAIT:  if (rx_sync) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rxd;
      rx_sync   <= rx_meta;
      valid     <= valid_d;
      frame_err <= err_d;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == RX_START) bit_idx <= '0;
      if (sample) begin
        data    <= {rx_sync, data[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end
endmodule

module final_mss_lite_uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  tx_state_t     state, state_d;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic          bit_end, last_bit, load, shift;

  assign bit_end  = (cnt == BIT_LAST);
  assign last_bit = (bit_idx == 4'd9);
  // Ready during the final stop-bit cycle lets the next byte follow with no gap.
  assign ready    = (state == TX_IDLE) || (bit_end && last_bit);
  assign busy     = (state == TX_BUSY);
  assign txd      = busy ? frame[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      TX_IDLE: if (start) begin load = 1'b1; state_d = TX_BUSY; end
      TX_BUSY: if (bit_end) begin
                 if (!last_bit)  shift   = 1'b1;
                 else if (start) load    = 1'b1;
                 else            state_d = TX_IDLE;
               end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame   <= '1;
      bit_idx <= '0;
      cnt     <= '0;
    end else if (load) begin
      frame   <= {1'b1, data, 1'b0};
      bit_idx <= '0;
      cnt     <= '0;
    end else if (shift) begin
      frame   <= {1'b1, frame[9:1]};
      bit_idx <= bit_idx + 1'b1;
      cnt     <= '0;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end
endmodule

module final_mss_lite #(
  parameter int CLKS_PER_BIT = 87,
  parameter int APB_TIMEOUT  = 256,
  parameter int RESET_HOLD   = 16
) (
  input  logic        SYSCLK,
  input  logic        MSS_RESET,
  input  logic        MSSPREADY,
  input  logic        MSSPSLVERR,
  input  logic [31:0] MSSPRDATA,
  input  logic        UART_0_RXD,
  input  logic        UART_1_RXD,
  input  logic        ADCDirectInput_0,
  input  logic        VAREF1,
  output logic        MSSPSEL,
  output logic        MSSPENABLE,
  output logic        MSSPWRITE,
  output logic        M2F_RESET_N,
  output logic        FAB_CLK,
  output logic        M2F_GPO_31,
  output logic [19:0] MSSPADDR,
  output logic [31:0] MSSPWDATA,
  output logic        UART_0_TXD,
  output logic        UART_1_TXD
);
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_GPO   = 8'h47;
  localparam logic [7:0] OP_ADC   = 8'h41;
  localparam int TW = $clog2(APB_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(APB_TIMEOUT - 1);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD = HW'(RESET_HOLD);

  typedef enum logic [2:0] {
    C_IDLE, C_ADDR, C_WDATA, C_GPO, C_SETUP, C_ACCESS, C_RESP
  } cmd_state_t;

  cmd_state_t  state, state_d;
  logic        rx0_valid, rx0_err, rx1_valid, rx1_err;
  logic [7:0]  rx0_data, rx1_data;
  logic        tx0_start, tx0_ready, tx0_busy;
  logic        tx1_start, tx1_ready, tx1_busy;
  logic        is_write, pwrite, gpo;
  logic [1:0]  byte_cnt;
  logic [19:0] addr_sh, paddr;
  logic [23:0] data_sh;
  logic [31:0] pwdata;
  logic [39:0] resp_q;
  logic [2:0]  resp_len;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hold_cnt;
  logic        adc_meta, adc_sync;
  logic        buf_valid;
  logic [7:0]  buf_data;
  logic        unused_sigs;

  assign unused_sigs = VAREF1 ^ rx1_err ^ tx1_busy;

  assign FAB_CLK     = SYSCLK;
  assign M2F_RESET_N = (hold_cnt == HOLD);
  assign M2F_GPO_31  = gpo;
  assign MSSPSEL     = (state == C_SETUP) || (state == C_ACCESS);
  assign MSSPENABLE  = (state == C_ACCESS);
  assign MSSPWRITE   = pwrite;
  assign MSSPADDR    = paddr;
  assign MSSPWDATA   = pwdata;

  final_mss_lite_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx0 (
    .clk(SYSCLK), .rst(MSS_RESET), .rxd(UART_0_RXD),
    .valid(rx0_valid), .frame_err(rx0_err), .data(rx0_data)
  );
  final_mss_lite_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx0 (
    .clk(SYSCLK), .rst(MSS_RESET), .start(tx0_start), .data(resp_q[39:32]),
    .ready(tx0_ready), .busy(tx0_busy), .txd(UART_0_TXD)
  );
  final_mss_lite_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx1 (
    .clk(SYSCLK), .rst(MSS_RESET), .rxd(UART_1_RXD),
    .valid(rx1_valid), .frame_err(rx1_err), .data(rx1_data)
  );
  final_mss_lite_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx1 (
    .clk(SYSCLK), .rst(MSS_RESET), .start(tx1_start), .data(buf_data),
    .ready(tx1_ready), .busy(tx1_busy), .txd(UART_1_TXD)
  );

  always_ff @(posedge SYSCLK) begin
    if (MSS_RESET) state <= C_IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d   = state;
    tx0_start = 1'b0;
    case (state)
      C_IDLE:   if (rx0_valid) begin
                  case (rx0_data)
                    OP_WRITE, OP_READ: state_d = C_ADDR;
                    OP_GPO:            state_d = C_GPO;
                    OP_ADC:            state_d = C_RESP;
                    default:           state_d = C_IDLE;
                  endcase
                end
      C_ADDR:   if (rx0_err) state_d = C_IDLE;
                else if (rx0_valid && byte_cnt == 2'd2) state_d = is_write ? C_WDATA : C_SETUP;
      C_WDATA:  if (rx0_err) state_d = C_IDLE;
                else if (rx0_valid && byte_cnt == 2'd3) state_d = C_SETUP;
      C_GPO:    if (rx0_err) state_d = C_IDLE;
                else if (rx0_valid) state_d = C_RESP;
      C_SETUP:  state_d = C_ACCESS;
      C_ACCESS: if (MSSPREADY || tcnt == T_LAST) state_d = C_RESP;
      C_RESP:   if (resp_len != 3'd0) tx0_start = tx0_ready;
                else if (!tx0_busy)   state_d   = C_IDLE;
      default:  state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (MSS_RESET) begin
      is_write <= 1'b0;
      pwrite   <= 1'b0;
      gpo      <= 1'b0;
      byte_cnt <= '0;
      addr_sh  <= '0;
      data_sh  <= '0;
      paddr    <= '0;
      pwdata   <= '0;
      resp_q   <= '0;
      resp_len <= '0;
      tcnt     <= '0;
    end else begin
      case (state)
        C_IDLE:   if (rx0_valid) begin
                    is_write <= (rx0_data == OP_WRITE);
                    byte_cnt <= '0;
                    if (rx0_data == OP_ADC) begin
                      resp_q   <= {8'h00, 7'b0, adc_sync, 24'h0};
                      resp_len <= 3'd2;
                    end
                  end
        C_ADDR:   if (rx0_valid) begin
                    addr_sh  <= {addr_sh[11:0], rx0_data};
                    byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
                    if (byte_cnt == 2'd2 && !is_write) begin
                      paddr  <= {addr_sh[11:0], rx0_data};
                      pwrite <= 1'b0;
                    end
                  end
        C_WDATA:  if (rx0_valid) begin
                    data_sh  <= {data_sh[15:0], rx0_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                      paddr  <= addr_sh;
                      pwdata <= {data_sh, rx0_data};
                      pwrite <= 1'b1;
                    end
                  end
        C_GPO:    if (rx0_valid) begin
                    gpo      <= rx0_data[0];
                    resp_q   <= '0;
                    resp_len <= 3'd1;
                  end
        C_SETUP:  tcnt <= '0;
        C_ACCESS: begin
                    tcnt <= tcnt + 1'b1;
                    if (MSSPREADY) begin
                      resp_q   <= {(MSSPSLVERR ? 8'h01 : 8'h00), (is_write ? 32'h0 : MSSPRDATA)};
                      resp_len <= is_write ? 3'd1 : 3'd5;
                    end else if (tcnt == T_LAST) begin
                      resp_q   <= {8'h02, 32'h0};
                      resp_len <= is_write ? 3'd1 : 3'd5;
                    end
                  end
        C_RESP:   if (tx0_start) begin
                    resp_q   <= {resp_q[31:0], 8'h00};
                    resp_len <= resp_len - 3'd1;
                  end
        default:  ;
      endcase
    end
  end

  // Fabric reset and ADC synchronizer.
  always_ff @(posedge SYSCLK) begin
    if (MSS_RESET) begin
      hold_cnt <= '0;
      adc_meta <= 1'b0;
      adc_sync <= 1'b0;
    end else begin
      if (hold_cnt != HOLD) hold_cnt <= hold_cnt + 1'b1;
      adc_meta <= ADCDirectInput_0;
      adc_sync <= adc_meta;
    end
  end

  // Echo channel: one holding byte in front of the transmitter.
  assign tx1_start = buf_valid && tx1_ready;

  always_ff @(posedge SYSCLK) begin
    if (MSS_RESET) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else begin
      if (tx1_start) buf_valid <= 1'b0;
      if (rx1_valid && (!buf_valid || tx1_start)) begin
        buf_valid <= 1'b1;
        buf_data  <= rx1_data;
      end
    end
  end
endmodule

// File: tb/tb_final_mss_lite.sv
// Directed bench for final_mss_lite: command vectors from a table, plus hand-written
// sequences for reset release, framing error, echo channel and reset mid-transfer.

module tb_final_mss_lite;
  localparam int CPB = 87;

  logic        SYSCLK = 1'b0;
  logic        MSS_RESET = 1'b1;
  logic        MSSPREADY = 1'b0;
  logic        MSSPSLVERR = 1'b0;
  logic [31:0] MSSPRDATA = '0;
  logic        UART_0_RXD = 1'b1;
  logic        UART_1_RXD = 1'b1;
  logic        ADCDirectInput_0 = 1'b0;
  logic        VAREF1 = 1'b0;
  logic        MSSPSEL, MSSPENABLE, MSSPWRITE, M2F_RESET_N, FAB_CLK, M2F_GPO_31;
  logic [19:0] MSSPADDR;
  logic [31:0] MSSPWDATA;
  logic        UART_0_TXD, UART_1_TXD;

  int checks = 0;
  int failures = 0;
  int setup_cnt = 0;

  final_mss_lite dut (
    .SYSCLK(SYSCLK), .MSS_RESET(MSS_RESET), .MSSPREADY(MSSPREADY), .MSSPSLVERR(MSSPSLVERR),
    .MSSPRDATA(MSSPRDATA), .UART_0_RXD(UART_0_RXD), .UART_1_RXD(UART_1_RXD),
    .ADCDirectInput_0(ADCDirectInput_0), .VAREF1(VAREF1), .MSSPSEL(MSSPSEL),
    .MSSPENABLE(MSSPENABLE), .MSSPWRITE(MSSPWRITE), .M2F_RESET_N(M2F_RESET_N),
    .FAB_CLK(FAB_CLK), .M2F_GPO_31(M2F_GPO_31), .MSSPADDR(MSSPADDR), .MSSPWDATA(MSSPWDATA),
    .UART_0_TXD(UART_0_TXD), .UART_1_TXD(UART_1_TXD)
  );

  always #50 SYSCLK = ~SYSCLK;

  always @(negedge SYSCLK) if (MSSPSEL && !MSSPENABLE) setup_cnt++;

  initial begin
    #(150_000 * 100);
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] cmd;      // command bytes, first byte in [63:56]
    int          ncmd;
    int          ready_at; // ACCESS cycle on which PREADY is raised, 0 = never
    logic [31:0] prdata;
    logic        slverr;
    logic        adc;
    logic        bus;
    logic [19:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          acc;
    logic [39:0] resp;     // response bytes, first byte in [39:32]
    int          nresp;
    logic        gpo;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] cmd, input int ncmd, input int ready_at,
                              input logic [31:0] prdata, input logic slverr, input logic adc,
                              input logic bus, input logic [19:0] addr, input logic wr,
                              input logic [31:0] wdata, input int acc, input logic [39:0] resp,
                              input int nresp, input logic gpo);
    vec_t v;
    v.cmd = cmd; v.ncmd = ncmd; v.ready_at = ready_at; v.prdata = prdata; v.slverr = slverr;
    v.adc = adc; v.bus = bus; v.addr = addr; v.wr = wr; v.wdata = wdata; v.acc = acc;
    v.resp = resp; v.nresp = nresp; v.gpo = gpo;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_rxd(input bit ch, input logic v);
    if (ch) UART_1_RXD = v;
    else    UART_0_RXD = v;
  endtask

  function automatic logic txd_of(input bit ch);
    return ch ? UART_1_TXD : UART_0_TXD;
  endfunction

  task automatic uart_send(input bit ch, input logic [7:0] b, input bit stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_rxd(ch, fr[i]);
      repeat (CPB) @(negedge SYSCLK);
    end
    set_rxd(ch, 1'b1);
    repeat (stop_bit ? 8 : CPB) @(negedge SYSCLK);
  endtask

  // Returns at mid stop bit; ok=0 on timeout or bad framing.
  task automatic uart_get(input bit ch, input int budget, output logic [7:0] b, output bit ok);
    int n;
    logic st;
    n = 0; ok = 1'b0; b = '0;
    while (txd_of(ch) && n < budget) begin
      @(negedge SYSCLK);
      n++;
    end
    if (n < budget) begin
      repeat (CPB / 2) @(negedge SYSCLK);
      st = txd_of(ch);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge SYSCLK);
        b[i] = txd_of(ch);
      end
      repeat (CPB) @(negedge SYSCLK);
      ok = (st == 1'b0) && (txd_of(ch) == 1'b1);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int base;
    base = setup_cnt;
    MSSPRDATA = v.prdata;
    MSSPSLVERR = v.slverr;
    ADCDirectInput_0 = v.adc;
    MSSPREADY = 1'b0;
    fork
      begin
        for (int i = 0; i < v.ncmd; i++) uart_send(1'b0, v.cmd[63 - 8*i -: 8], 1'b1);
      end
      begin
        if (v.bus) begin
          bit seen;
          int n, acc;
          seen = 1'b0; n = 0;
          while (!seen && n < v.ncmd * 1000 + 1000) begin
            @(negedge SYSCLK);
            n++;
            seen = MSSPSEL && !MSSPENABLE;
          end
          check({tag, "_setup_seen"}, 64'(seen), 64'd1);
          if (seen) begin
            check({tag, "_addr"},  64'(MSSPADDR),  64'(v.addr));
            check({tag, "_write"}, 64'(MSSPWRITE), 64'(v.wr));
            check({tag, "_wdata"}, 64'(MSSPWDATA), 64'(v.wdata));
            acc = 0;
            @(negedge SYSCLK);
            while (MSSPSEL && MSSPENABLE && acc < 400) begin
              acc++;
              if (acc == v.ready_at) MSSPREADY = 1'b1;
              @(negedge SYSCLK);
            end
            MSSPREADY = 1'b0;
            check({tag, "_access_cycles"}, 64'(acc), 64'(v.acc));
            check({tag, "_bus_idle_after"}, 64'({MSSPSEL, MSSPENABLE}), 64'd0);
          end
        end
      end
      begin
        logic [7:0] rb;
        bit ok;
        for (int i = 0; i < v.nresp; i++) begin
          uart_get(1'b0, (i == 0) ? v.ncmd * 1000 + 1500 : 3000, rb, ok);
          check($sformatf("%s_resp%0d", tag, i), 64'(rb), 64'(v.resp[39 - 8*i -: 8]));
          check($sformatf("%s_resp%0d_frame", tag, i), 64'(ok), 64'd1);
        end
      end
    join
    check({tag, "_setup_count"}, 64'(setup_cnt - base), v.bus ? 64'd1 : 64'd0);
    check({tag, "_gpo"}, 64'(M2F_GPO_31), 64'(v.gpo));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(64'h57000123_DEADBEEF, 8, 2, 32'h0, 1'b0, 1'b0, 1'b1, 20'h00123, 1'b1,
                 32'hDEADBEEF, 2, 40'h00_00000000, 1, 1'b0);
    vecs[1] = mk(64'h520FFFFC_00000000, 4, 1, 32'h12345678, 1'b0, 1'b0, 1'b1, 20'hFFFFC, 1'b0,
                 32'hDEADBEEF, 1, 40'h00_12345678, 5, 1'b0);
    vecs[2] = mk(64'h52000040_00000000, 4, 0, 32'h55AA55AA, 1'b0, 1'b0, 1'b1, 20'h00040, 1'b0,
                 32'hDEADBEEF, 256, 40'h02_00000000, 5, 1'b0);
    vecs[3] = mk(64'h52000010_00000000, 4, 3, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 20'h00010, 1'b0,
                 32'hDEADBEEF, 3, 40'h01_CAFEF00D, 5, 1'b0);
    vecs[4] = mk(64'h4701_0000_00000000, 2, 0, 32'h0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0,
                 32'h0, 0, 40'h00_00000000, 1, 1'b1);
    vecs[5] = mk(64'h41_000000_00000000, 1, 0, 32'h0, 1'b0, 1'b1, 1'b0, 20'h0, 1'b0,
                 32'h0, 0, 40'h0001_000000, 2, 1'b1);
    vecs[6] = mk(64'h9941_0000_00000000, 2, 0, 32'h0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0,
                 32'h0, 0, 40'h0000_000000, 2, 1'b1);
    vecs[7] = mk(64'h4700_0000_00000000, 2, 0, 32'h0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0,
                 32'h0, 0, 40'h00_00000000, 1, 1'b0);

    // Reset held 10 cycles, outputs at reset values, fabric reset released 16 cycles later.
    repeat (10) @(negedge SYSCLK);
    check("reset_ctrl_outputs",
          64'({MSSPSEL, MSSPENABLE, MSSPWRITE, M2F_GPO_31, M2F_RESET_N, UART_0_TXD, UART_1_TXD}),
          64'b0000011);
    check("reset_addr", 64'(MSSPADDR), 64'h0);
    check("reset_wdata", 64'(MSSPWDATA), 64'h0);
    check("fab_clk_low", 64'(FAB_CLK), 64'd0);
    MSS_RESET = 1'b0;
    begin
      bit early;
      early = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        @(negedge SYSCLK);
        if (M2F_RESET_N) early = 1'b1;
      end
      check("m2f_reset_n_held_15", 64'(early), 64'd0);
      @(negedge SYSCLK);
      check("m2f_reset_n_at_16", 64'(M2F_RESET_N), 64'd1);
    end
    repeat (20) @(negedge SYSCLK);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Framing error in the 2nd address byte, then a valid read.
    begin
      int base;
      base = setup_cnt;
      uart_send(1'b0, 8'h52, 1'b1);
      uart_send(1'b0, 8'h00, 1'b1);
      uart_send(1'b0, 8'h77, 1'b0);
      repeat (200) @(negedge SYSCLK);
      check("frame_err_no_bus", 64'(setup_cnt - base), 64'd0);
      check("frame_err_no_reply", 64'(UART_0_TXD), 64'd1);
      run_vec("after_frame_err",
              mk(64'h520ABCDE_00000000, 4, 1, 32'h0BADF00D, 1'b0, 1'b0, 1'b1, 20'hABCDE, 1'b0,
                 32'hDEADBEEF, 1, 40'h00_0BADF00D, 5, 1'b0));
    end

    // UART_1 echo, two bytes close together.
    fork
      begin
        uart_send(1'b1, 8'hA5, 1'b1);
        uart_send(1'b1, 8'h3C, 1'b1);
      end
      begin
        logic [7:0] rb;
        bit ok;
        uart_get(1'b1, 2000, rb, ok);
        check("echo_byte0", 64'(rb), 64'hA5);
        check("echo_byte0_frame", 64'(ok), 64'd1);
        uart_get(1'b1, 3000, rb, ok);
        check("echo_byte1", 64'(rb), 64'h3C);
        check("echo_byte1_frame", 64'(ok), 64'd1);
      end
    join

    // Reset during ACCESS aborts the transfer with no reply.
    begin
      int n;
      bit low_seen;
      MSSPREADY = 1'b0;
      for (int i = 0; i < 4; i++) uart_send(1'b0, (i == 0) ? 8'h52 : 8'h20, 1'b1);
      n = 0;
      while (!MSSPENABLE && n < 2000) begin
        @(negedge SYSCLK);
        n++;
      end
      check("midreset_in_access", 64'(MSSPENABLE), 64'd1);
      repeat (20) @(negedge SYSCLK);
      MSS_RESET = 1'b1;
      @(negedge SYSCLK);
      MSS_RESET = 1'b0;
      check("midreset_bus_idle", 64'({MSSPSEL, MSSPENABLE, MSSPWRITE}), 64'd0);
      check("midreset_addr", 64'(MSSPADDR), 64'h0);
      check("midreset_fabric_reset", 64'(M2F_RESET_N), 64'd0);
      low_seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge SYSCLK);
        if (!UART_0_TXD) low_seen = 1'b1;
      end
      check("midreset_no_reply", 64'(low_seen), 64'd0);
      check("midreset_bus_stays_idle", 64'({MSSPSEL, MSSPENABLE}), 64'd0);
      check("midreset_fabric_reset_back", 64'(M2F_RESET_N), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/final_mss_lite.md
Name:
final_mss_lite

Overview:
- Synthesizable stand-in for the microcontroller subsystem of the final design.
- Turns a byte command stream on UART_0 into APB3 master transactions on the MSSP fabric bus, and answers on UART_0.
- Also provides a UART_1 echo channel, one general-purpose output (GPO 31), a sampled ADC direct comparator input, the fabric clock and the fabric reset.

Parameters:
- CLKS_PER_BIT, 87, SYSCLK cycles per UART bit (10 MHz / 115200).
- APB_TIMEOUT, 256, ACCESS cycles allowed without MSSPREADY before abort.
- RESET_HOLD, 16, cycles M2F_RESET_N stays low after reset release.

Ports:
- SYSCLK  in  1  system clock, 10 MHz nominal.
- MSS_RESET  in  1  reset; one clock; reset is synchronous and active-high.
- MSSPREADY  in  1  APB ready from fabric slave.
- MSSPSLVERR  in  1  APB slave error.
- MSSPRDATA  in  32  APB read data.
- UART_0_RXD  in  1  command UART receive, idle high.
- UART_1_RXD  in  1  echo UART receive, idle high.
- ADCDirectInput_0  in  1  comparator input, asynchronous.
- VAREF1  in  1  analog reference; ignored.
- MSSPSEL  out  1  APB select.
- MSSPENABLE  out  1  APB enable.
- MSSPWRITE  out  1  APB direction; 1 means write.
- M2F_RESET_N  out  1  active-low fabric reset.
- FAB_CLK  out  1  fabric clock, equal to SYSCLK (combinational pass-through).
- M2F_GPO_31  out  1  general-purpose output.
- MSSPADDR  out  20  APB address.
- MSSPWDATA  out  32  APB write data.
- UART_0_TXD  out  1  command UART transmit.
- UART_1_TXD  out  1  echo UART transmit.

Behaviour:
- Reset values:
  - MSSPSEL, MSSPENABLE, MSSPWRITE = 0.
  - MSSPADDR and MSSPWDATA = 0.
  - Both TXD = 1.
  - M2F_GPO_31 = 0.
  - M2F_RESET_N = 0.
  - All FSMs return to IDLE; partial commands and UART bytes are discarded.
- M2F_RESET_N: 0 while MSS_RESET=1, and for RESET_HOLD cycles after the first clock with MSS_RESET=0; then 1.
- UART format: 8N1, LSB first.
  - RXD passes through a 2-flop synchronizer.
  - A start bit is accepted if still low at mid-bit; each bit is sampled at mid-bit.
  - Stop bit = 0 is a framing error: the byte is dropped and the command parser returns to IDLE.
- UART TX: sends queued bytes back to back, with one stop bit each.
- Command FSM (UART_0). Multi-byte fields are MSB first; the address field is 3 bytes, of which the low 20 bits are used.
  - 0x57 'W' + addr[3] + data[4]: APB write. Response is 1 status byte.
  - 0x52 'R' + addr[3]: APB read. Response is status byte + data[4].
  - 0x47 'G' + b: M2F_GPO_31 <= b[0] one cycle after byte b is received. Response 0x00.
  - 0x41 'A': response is 0x00 followed by {7'b0, synchronized ADCDirectInput_0} (2-flop synchronizer).
  - Any other opcode: ignored silently; FSM stays in IDLE.
  - Bytes arriving while a response is in progress are dropped.
- Status codes: 0x00 OK, 0x01 MSSPSLVERR seen, 0x02 timeout.
- APB3 master, starting the cycle after the last command byte:
  - SETUP cycle: PSEL=1, ENABLE=0, ADDR/WRITE/WDATA valid.
  - ACCESS: PSEL=1, ENABLE=1, held until MSSPREADY=1.
  - PRDATA and PSLVERR are sampled on the ready cycle.
  - Next cycle: PSEL=0, ENABLE=0.
  - ADDR and WDATA hold their last values after the transfer.
- Timeout: if MSSPREADY=0 for APB_TIMEOUT consecutive ACCESS cycles, drop PSEL/ENABLE and report status 0x02. Read data for a timeout is 0x00000000.
- SLVERR on a read returns status 0x01 and the sampled PRDATA.
- Reset mid-transfer aborts immediately: the bus goes idle and no response is sent.
- UART_1: each correctly received byte is retransmitted on UART_1_TXD, with one byte of buffering.
  - A byte received while both the buffer and the transmitter are busy is dropped.

Test Plan:
- Reset held 10 cycles, then released -> all outputs at reset values; M2F_RESET_N rises exactly RESET_HOLD=16 cycles after release.
- UART_0 bytes 57 00 01 23 DE AD BE EF, slave ready on 2nd ACCESS cycle:
  - Bus: SETUP with MSSPADDR=0x00123, MSSPWDATA=0xDEADBEEF, WRITE=1; then two ENABLE cycles.
  - TX response 0x00.
- UART_0 bytes 52 0F FF FC, PRDATA=0x12345678, PREADY=1 immediately -> WRITE=0, MSSPADDR=0xFFFFC; TX 00 12 34 56 78.
- Read with MSSPREADY tied 0 -> PSEL/ENABLE drop after 256 ACCESS cycles; TX 02 00 00 00 00.
- Command 47 01 then 41 with ADCDirectInput_0=1:
  - M2F_GPO_31=1; TX 00.
  - Then TX 00 01.
- Framing error in the 2nd address byte followed by a valid 'R' command -> no bus activity for the broken command; the valid read completes normally. UART_1 byte 0xA5 -> echoed 0xA5 on UART_1_TXD.
